// File: rtl/viterbi_pkg.sv
// Shared constants, pm_t, and the helpers for the K=3, rate-1/2 (7,5) Viterbi ACS stage.
package viterbi_pkg;

    localparam int         K          = 3;
    localparam int         NUM_STATES = 4;
    localparam logic [2:0] G0         = 3'b111;
    localparam logic [2:0] G1         = 3'b101;
    localparam int         PM_INIT    = 8;
    localparam int         PM_W_DEF   = 6;

    typedef logic [PM_W_DEF-1:0] pm_t;

    // Encoder register is {u, s1, s0}; each generator taps it and XOR-reduces.
    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
        logic [2:0] taps;
        taps = {u, state};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    function automatic logic [1:0] ham2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/acs_unit.sv
// One add-compare-select cell: adds branch metrics, picks the smaller (tie -> p0), saturates.
module acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    logic [PM_W:0] c0;
    logic [PM_W:0] c1;
    logic [PM_W:0] sel;

    always_comb begin
        c0    = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
        c1    = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
        dec_o = (c1 < c0);
        sel   = dec_o ? c1 : c0;
        pm_o  = sel[PM_W] ? {PM_W{1'b1}} : sel[PM_W-1:0];
    end

endmodule

// File: rtl/viterbi_acs.sv
// Branch metrics, four ACS cells, min/argmin normalisation and output registers.
// o_valid pulses for one cycle per accepted symbol; there is no ready, so downstream must take every pulse.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int SIZE_IN = 2,
    parameter int PM_W    = PM_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_valid,
    input  logic [SIZE_IN-1:0]   i_data,
    output logic                 o_valid,
    output logic [3:0]           o_dec,
    output logic [1:0]           o_best,
    output logic [4*PM_W-1:0]    o_pm
);

    localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_RST =
        {PM_W'(PM_INIT), PM_W'(PM_INIT), PM_W'(PM_INIT), PM_W'(0)};

    logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_d;
    logic [NUM_STATES-1:0][PM_W-1:0] acs_pm;
    logic [NUM_STATES-1:0][PM_W-1:0] pm_norm;
    logic [3:0]                      dec_q, dec_d, acs_dec;
    logic [1:0]                      best_q, best_d, best_new;
    logic                            valid_q, valid_d;
    logic [PM_W-1:0]                 min_pm;

    // Predecessors of N are {N[0],0} and {N[0],1}; the branch input is N[1].
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam logic [1:0] NS = 2'(n);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};

        logic [1:0] bm0, bm1;
        assign bm0 = ham2(i_data[1:0], exp_sym(P0, NS[1]));
        assign bm1 = ham2(i_data[1:0], exp_sym(P1, NS[1]));

        acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (acs_pm[n]),
            .dec_o (acs_dec[n])
        );
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_pm   = acs_pm[0];
        best_new = 2'd0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (acs_pm[i] < min_pm) begin
                min_pm   = acs_pm[i];
                best_new = i[1:0];
            end
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_norm[i] = acs_pm[i] - min_pm;
        end
    end

    always_comb begin
        pm_d    = pm_q;
        dec_d   = dec_q;
        best_d  = best_q;
        valid_d = 1'b0;
        if (i_clr) begin
            pm_d = PM_RST;
        end else if (i_valid) begin
            pm_d    = pm_norm;
            dec_d   = acs_dec;
            best_d  = best_new;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pm_q    <= PM_RST;
            dec_q   <= 4'b0000;
            best_q  <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            pm_q    <= pm_d;
            dec_q   <= dec_d;
            best_q  <= best_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_dec   = dec_q;
    assign o_best  = best_q;
    assign o_pm    = pm_q;

endmodule

// File: tb/tb_viterbi_acs.sv
// Directed table-driven bench for viterbi_acs with gap, clear, reset and random-error sequences.
module tb_viterbi_acs;

    localparam int PM_W = 6;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_clr;
    logic              i_valid;
    logic [1:0]        i_data;
    logic              o_valid;
    logic [3:0]        o_dec;
    logic [1:0]        o_best;
    logic [4*PM_W-1:0] o_pm;

    viterbi_acs #(.SIZE_IN(2), .PM_W(PM_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_dec   (o_dec),
        .o_best  (o_best),
        .o_pm    (o_pm)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]        sym;
        logic [3:0]        dec;
        logic [1:0]        best;
        logic [4*PM_W-1:0] pm;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    vec_t vt[8];
    vec_t verr;
    logic [4*PM_W-1:0] pm_init;

    always @(negedge i_clk) if (o_valid) pulse_cnt++;

    function automatic logic [4*PM_W-1:0] pk(input int a, input int b, input int c, input int d);
        return {PM_W'(d), PM_W'(c), PM_W'(b), PM_W'(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input vec_t v);
        check({name, ".valid"}, 32'(o_valid), 32'd1);
        check({name, ".dec"},   32'(o_dec),   32'(v.dec));
        check({name, ".best"},  32'(o_best),  32'(v.best));
        check({name, ".pm"},    32'(o_pm),    32'(v.pm));
    endtask

    // Drive a symbol for one edge and leave the bench 1 time unit past that edge.
    task automatic send(input logic [1:0] sym);
        i_valid = 1'b1;
        i_data  = sym;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [1:0] enc;
        logic       u;
        logic [1:0] sym;
        int         mx;
        int         mn;
        int         v;

        pm_init = pk(0, 8, 8, 8);
        vt[0] = '{2'b11, 4'b0000, 2'd2, pk(2, 9, 0, 9)};
        vt[1] = '{2'b01, 4'b0000, 2'd3, pk(3, 2, 3, 0)};
        vt[2] = '{2'b01, 4'b1111, 2'd1, pk(3, 0, 3, 2)};
        vt[3] = '{2'b00, 4'b1111, 2'd2, pk(2, 3, 0, 3)};
        vt[4] = '{2'b01, 4'b0000, 2'd3, pk(3, 2, 3, 0)};
        vt[5] = '{2'b01, 4'b1111, 2'd1, pk(3, 0, 3, 2)};
        vt[6] = '{2'b00, 4'b1111, 2'd2, pk(2, 3, 0, 3)};
        vt[7] = '{2'b10, 4'b0000, 2'd1, pk(3, 0, 3, 2)};
        // From {3,2,3,0}, symbol 11 matches no branch out of state 3: raw {2,1,3,1} normalises to {1,0,2,0}.
        verr  = '{2'b11, 4'b1011, 2'd1, pk(1, 0, 2, 0)};

        i_clr   = 1'b0;
        i_valid = 1'b0;
        i_data  = 2'b00;
        do_reset();

        check("rst.valid", 32'(o_valid), 32'd0);
        check("rst.dec",   32'(o_dec),   32'd0);
        check("rst.best",  32'(o_best),  32'd0);
        check("rst.pm",    32'(o_pm),    32'(pm_init));

        for (int i = 0; i < 8; i++) begin
            send(vt[i].sym);
            check_vec($sformatf("b2b[%0d]", i), vt[i]);
        end

        // Clear wins over a simultaneous valid symbol.
        i_clr   = 1'b1;
        i_valid = 1'b1;
        i_data  = 2'b11;
        @(posedge i_clk);
        #1;
        i_clr   = 1'b0;
        i_valid = 1'b0;
        check("clr.valid", 32'(o_valid), 32'd0);
        check("clr.pm",    32'(o_pm),    32'(pm_init));

        send(vt[0].sym);
        check_vec("clr.s0", vt[0]);
        send(vt[1].sym);
        check_vec("clr.s1", vt[1]);
        send(verr.sym);
        check_vec("norm_err", verr);

        i_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr = 1'b0;
        check("clr2.pm", 32'(o_pm), 32'(pm_init));

        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send(vt[i].sym);
            check_vec($sformatf("gap[%0d]", i), vt[i]);
            repeat ($urandom_range(1, 3)) begin
                @(posedge i_clk);
                #1;
                check("gap.valid_low", 32'(o_valid), 32'd0);
                check("gap.pm_hold",   32'(o_pm),    32'(vt[i].pm));
                check("gap.best_hold", 32'(o_best),  32'(vt[i].best));
            end
        end
        check("gap.pulses", 32'(pulse_cnt), 32'd8);

        send(vt[0].sym);
        send(vt[1].sym);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(o_valid), 32'd0);
        check("arst.dec",   32'(o_dec),   32'd0);
        check("arst.best",  32'(o_best),  32'd0);
        check("arst.pm",    32'(o_pm),    32'(pm_init));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        send(vt[0].sym);
        check_vec("arst.first", vt[0]);

        enc = 2'b10;
        for (int n = 0; n < 1000; n++) begin
            u   = 1'($urandom_range(0, 1));
            sym = {u ^ enc[1] ^ enc[0], u ^ enc[0]};
            if ($urandom_range(0, 9) == 0) sym[$urandom_range(0, 1)] ^= 1'b1;
            enc = {u, enc[1]};
            send(sym);
            mx = 0;
            mn = 1 << PM_W;
            for (int s = 0; s < 4; s++) begin
                v  = int'(o_pm[s*PM_W +: PM_W]);
                mx = (v > mx) ? v : mx;
                mn = (v < mn) ? v : mn;
            end
            check("rnd.valid", 32'(o_valid), 32'd1);
            check("rnd.max_le8", 32'(mx <= 8), 32'd1);
            check("rnd.min0", 32'(mn), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
